// File: rtl/fetch_if.sv
// Controller/memory-side bundle for fetch_unit. pc_trap exists only when
// FETCH_PC_WRAP_TRAP_EN is defined.
interface fetch_if;
  logic        LoadIR;
  logic        IncPC;
  logic        SelPC;
  logic        LoadPC;
  logic        z;
  logic        c;
  logic [7:0]  reg_val;
  logic [7:0]  mem_data;
  logic [7:0]  mem_addr;
  logic [3:0]  op;
  logic [3:0]  imm;
  logic        jump_taken;
  logic [15:0] fetch_cnt;
`ifdef FETCH_PC_WRAP_TRAP_EN
  logic        pc_trap;
`endif

  modport slave (
    input  LoadIR, IncPC, SelPC, LoadPC, z, c, reg_val, mem_data,
    output mem_addr, op, imm, jump_taken, fetch_cnt
`ifdef FETCH_PC_WRAP_TRAP_EN
    , output pc_trap
`endif
  );

  modport master (
    output LoadIR, IncPC, SelPC, LoadPC, z, c, reg_val, mem_data,
    input  mem_addr, op, imm, jump_taken, fetch_cnt
`ifdef FETCH_PC_WRAP_TRAP_EN
    , input pc_trap
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR, conditional jumps and a saturating fetch counter.
// Optional sticky PC-wrap trap enabled by FETCH_PC_WRAP_TRAP_EN.
module fetch_unit (
  input  logic   clk,
  input  logic   CLB,
  fetch_if.slave bus
);
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic        jump_taken_q, jump_taken_d;
  logic        jump_cond;
  logic        pc_lock;
`ifdef FETCH_PC_WRAP_TRAP_EN
  logic        pc_trap_q, pc_trap_d;
`endif

  always_comb begin
    case (ir_q[7:4])
      4'h6, 4'h7: jump_cond = bus.z;
      4'h8, 4'hA: jump_cond = bus.c;
      default:    jump_cond = 1'b1;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    fetch_cnt_d  = fetch_cnt_q;
    jump_taken_d = 1'b0;
`ifdef FETCH_PC_WRAP_TRAP_EN
    pc_trap_d    = pc_trap_q;
    pc_lock      = pc_trap_q;
`else
    pc_lock      = 1'b0;
`endif
    if (bus.LoadIR) begin
      ir_d = bus.mem_data;
      if (fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
    // LoadPC wins over IncPC; a trapped PC ignores both.
    if (!pc_lock) begin
      if (bus.LoadPC) begin
        if (jump_cond) begin
          pc_d         = bus.SelPC ? bus.reg_val : {pc_q[7:4], ir_q[3:0]};
          jump_taken_d = 1'b1;
        end
      end else if (bus.IncPC) begin
`ifdef FETCH_PC_WRAP_TRAP_EN
        if (pc_q == 8'hFF) pc_trap_d = 1'b1;
        else               pc_d      = pc_q + 8'd1;
`else
        pc_d = pc_q + 8'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      pc_q         <= 8'h00;
      ir_q         <= 8'h00;
      fetch_cnt_q  <= 16'h0000;
      jump_taken_q <= 1'b0;
`ifdef FETCH_PC_WRAP_TRAP_EN
      pc_trap_q    <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      fetch_cnt_q  <= fetch_cnt_d;
      jump_taken_q <= jump_taken_d;
`ifdef FETCH_PC_WRAP_TRAP_EN
      pc_trap_q    <= pc_trap_d;
`endif
    end
  end

  assign bus.mem_addr   = pc_q;
  assign bus.op         = ir_q[7:4];
  assign bus.imm        = ir_q[3:0];
  assign bus.jump_taken = jump_taken_q;
  assign bus.fetch_cnt  = fetch_cnt_q;
`ifdef FETCH_PC_WRAP_TRAP_EN
  assign bus.pc_trap    = pc_trap_q;
`endif
endmodule
